// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared types and constants for the two-port data-memory arbiter.
//   arb_state_e : arbiter FSM states (IDLE, LOCK0, LOCK1)
//   req_idx_t   : requester index (0 = processor, 1 = debug/DMA)
//   DEF_AW/DW   : default address / data widths
//   LOCK_CNT_W  : width of the locked-grant counter (LOCK_MAX range 1..15)
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_e;

    typedef logic req_idx_t;

    localparam int DEF_AW     = 8;
    localparam int DEF_DW     = 8;
    localparam int LOCK_CNT_W = 4;

endpackage

// File: rtl/dmem_arb_rr.sv
// -----------------------------------------------------------------------------
// dmem_arb_rr
// Two-way round-robin pick. A lone requester always wins; on a tie the
// requester that was NOT granted last wins.
// Ports:
//   i_reqs     : request vector {m1, m0}
//   i_last_gnt : index of the most recently granted requester
//   o_gnt      : one-hot grant {m1, m0}, all-zero when nobody requests
// -----------------------------------------------------------------------------
module dmem_arb_rr
    import dmem_arb_pkg::*;
(
    input  logic [1:0] i_reqs,
    input  req_idx_t   i_last_gnt,
    output logic [1:0] o_gnt
);

    always_comb begin
        o_gnt = 2'b00;
        case (i_reqs)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = i_last_gnt ? 2'b01 : 2'b10;
            default: o_gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Arbitrates a single-port data memory between a processor (m0) and a
// debug/DMA master (m1). One access is issued per cycle; reads return data
// exactly one cycle after the grant.
//
// Configuration macro: DMEM_ARB_LOCK_EN
//   defined   : requesters may hold ownership with mN_lock for up to LOCK_MAX
//               consecutive grants while the other side is waiting.
//   undefined : mN_lock is ignored, pure per-cycle round-robin.
//
// Ports:
//   clk, rst (async, active-low)
//   mN_req/we/lock/addr/wdata : requester N access request (N = 0, 1)
//   mN_gnt                    : access issued this cycle (combinational)
//   mN_rvalid/rdata           : read return, one cycle after a granted read
//   data_mem_*_o              : memory strobes, address and write data
//   data_mem_rd_data_i        : memory read data, one cycle after rd_enb
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW       = DEF_AW,
    parameter int DW       = DEF_DW,
    parameter int LOCK_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          m0_req,
    input  logic          m0_we,
    input  logic          m0_lock,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,

    input  logic          m1_req,
    input  logic          m1_we,
    input  logic          m1_lock,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,

    output logic          data_mem_rd_enb_o,
    output logic          data_mem_wr_enb_o,
    output logic [AW-1:0] data_mem_addr_o,
    output logic [DW-1:0] data_mem_wr_data_o,
    input  logic [DW-1:0] data_mem_rd_data_i
);

    // r_run holds grants off until the first rising edge after reset release.
    logic       r_run;
    req_idx_t   r_last_gnt;
    logic [1:0] r_rvalid;
    logic [1:0] w_reqs;
    logic [1:0] w_rr_gnt;
    logic [1:0] w_gnt;

    assign w_reqs = {m1_req, m0_req} & {2{r_run}};

    dmem_arb_rr u_rr (
        .i_reqs     (w_reqs),
        .i_last_gnt (r_last_gnt),
        .o_gnt      (w_rr_gnt)
    );

`ifdef DMEM_ARB_LOCK_EN
    localparam logic [LOCK_CNT_W-1:0] LOCK_MAX_C = LOCK_CNT_W'(LOCK_MAX);

    arb_state_e            r_state;
    arb_state_e            w_state_nxt;
    logic [LOCK_CNT_W-1:0] r_lock_cnt;
    logic [LOCK_CNT_W-1:0] w_lock_cnt_nxt;
    logic [1:0]            w_lock;
    logic                  w_own;
    logic                  w_hold;

    assign w_lock = {m1_lock, m0_lock};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_lock_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
        end
    end

    // A locked owner keeps the grant while it requests, unless its budget is
    // spent and the other side is waiting. Any release cycle arbitrates like
    // IDLE so no cycle is lost; since the owner was granted last, the
    // round-robin pick hands the memory to the waiting requester.
    always_comb begin
        w_gnt          = w_rr_gnt;
        w_state_nxt    = IDLE;
        w_lock_cnt_nxt = '0;
        w_own          = (r_state == LOCK1);
        w_hold         = 1'b0;

        if (r_state != IDLE) begin
            w_hold = w_reqs[w_own] &&
                     !((r_lock_cnt == LOCK_MAX_C) && w_reqs[~w_own]);
        end

        if (w_hold) begin
            w_gnt = w_own ? 2'b10 : 2'b01;
            if (w_lock[w_own]) begin
                w_state_nxt    = r_state;
                // Saturate: with nobody else waiting the owner may continue.
                w_lock_cnt_nxt = (r_lock_cnt == LOCK_MAX_C) ? r_lock_cnt
                                                            : r_lock_cnt + 1'b1;
            end
        end else if (w_rr_gnt[0] && m0_lock) begin
            w_state_nxt    = LOCK0;
            w_lock_cnt_nxt = LOCK_CNT_W'(1);
        end else if (w_rr_gnt[1] && m1_lock) begin
            w_state_nxt    = LOCK1;
            w_lock_cnt_nxt = LOCK_CNT_W'(1);
        end
    end
`else
    localparam int lock_max_unused = LOCK_MAX;
    logic w_unused_lock;

    assign w_unused_lock = m0_lock ^ m1_lock;
    assign w_gnt         = w_rr_gnt;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_run      <= 1'b0;
            r_last_gnt <= 1'b1;
            r_rvalid   <= 2'b00;
        end else begin
            r_run <= 1'b1;
            if (|w_gnt) begin
                r_last_gnt <= w_gnt[1];
            end
            r_rvalid <= w_gnt & ~{m1_we, m0_we};
        end
    end

    assign m0_gnt    = w_gnt[0];
    assign m1_gnt    = w_gnt[1];
    assign m0_rvalid = r_rvalid[0];
    assign m1_rvalid = r_rvalid[1];
    assign m0_rdata  = r_rvalid[0] ? data_mem_rd_data_i : '0;
    assign m1_rdata  = r_rvalid[1] ? data_mem_rd_data_i : '0;

    always_comb begin
        data_mem_rd_enb_o  = 1'b0;
        data_mem_wr_enb_o  = 1'b0;
        data_mem_addr_o    = '0;
        data_mem_wr_data_o = '0;
        if (w_gnt[0]) begin
            data_mem_rd_enb_o  = ~m0_we;
            data_mem_wr_enb_o  = m0_we;
            data_mem_addr_o    = m0_addr;
            data_mem_wr_data_o = m0_wdata;
        end else if (w_gnt[1]) begin
            data_mem_rd_enb_o  = ~m1_we;
            data_mem_wr_enb_o  = m1_we;
            data_mem_addr_o    = m1_addr;
            data_mem_wr_data_o = m1_wdata;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    logic       clk;
    logic       rst;
    logic       m0_req, m0_we, m0_lock;
    logic [7:0] m0_addr, m0_wdata;
    logic       m0_gnt, m0_rvalid;
    logic [7:0] m0_rdata;
    logic       m1_req, m1_we, m1_lock;
    logic [7:0] m1_addr, m1_wdata;
    logic       m1_gnt, m1_rvalid;
    logic [7:0] m1_rdata;
    logic       rd_enb, wr_enb;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;

    int n_vec = 0;
    int n_err = 0;

    dmem_arbiter #(.AW(8), .DW(8), .LOCK_MAX(4)) dut (
        .clk                (clk),
        .rst                (rst),
        .m0_req             (m0_req),
        .m0_we              (m0_we),
        .m0_lock            (m0_lock),
        .m0_addr            (m0_addr),
        .m0_wdata           (m0_wdata),
        .m0_gnt             (m0_gnt),
        .m0_rvalid          (m0_rvalid),
        .m0_rdata           (m0_rdata),
        .m1_req             (m1_req),
        .m1_we              (m1_we),
        .m1_lock            (m1_lock),
        .m1_addr            (m1_addr),
        .m1_wdata           (m1_wdata),
        .m1_gnt             (m1_gnt),
        .m1_rvalid          (m1_rvalid),
        .m1_rdata           (m1_rdata),
        .data_mem_rd_enb_o  (rd_enb),
        .data_mem_wr_enb_o  (wr_enb),
        .data_mem_addr_o    (mem_addr),
        .data_mem_wr_data_o (mem_wdata),
        .data_mem_rd_data_i (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = 0; m1_wdata = 0;
        mem_rdata = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 0;
        next_cycle();
        rst = 1;
        next_cycle();
    endtask

    task automatic test_reset();
        rst = 0;
        clear_inputs();
        m0_req = 1; m1_req = 1; m0_addr = 8'h44; m1_addr = 8'h55;
        mem_rdata = 8'hFF;
        next_cycle();
        n_vec++;
        if ({m1_gnt, m0_gnt} !== 2'b00) begin
            n_err++; $display("FAIL reset_gnt: got %b want 00", {m1_gnt, m0_gnt});
        end
        n_vec++;
        if ({rd_enb, wr_enb, mem_addr, mem_wdata} !== 18'h0) begin
            n_err++; $display("FAIL reset_mem: got %h want 0", {rd_enb, wr_enb, mem_addr, mem_wdata});
        end
        n_vec++;
        if ({m1_rvalid, m0_rvalid, m1_rdata, m0_rdata} !== 18'h0) begin
            n_err++; $display("FAIL reset_rd: got %h want 0", {m1_rvalid, m0_rvalid, m1_rdata, m0_rdata});
        end
        // release mid-cycle: no grant until the next rising edge
        rst = 1;
        #1;
        n_vec++;
        if ({m1_gnt, m0_gnt} !== 2'b00) begin
            n_err++; $display("FAIL release_early_gnt: got %b want 00", {m1_gnt, m0_gnt});
        end
        @(posedge clk);
        #1;
        n_vec++;
        if ({m1_gnt, m0_gnt, mem_addr} !== {2'b01, 8'h44}) begin
            n_err++; $display("FAIL first_tie: got %h want %h", {m1_gnt, m0_gnt, mem_addr}, {2'b01, 8'h44});
        end
        clear_inputs();
    endtask

    task automatic test_read();
        do_reset();
        m0_req = 1; m0_we = 0; m0_addr = 8'h10;
        #1;
        n_vec++;
        if ({m1_gnt, m0_gnt, rd_enb, wr_enb, mem_addr} !== {4'b0110, 8'h10}) begin
            n_err++; $display("FAIL read_issue: got %h want %h", {m1_gnt, m0_gnt, rd_enb, wr_enb, mem_addr}, {4'b0110, 8'h10});
        end
        next_cycle();
        m0_req = 0; mem_rdata = 8'hA5;
        #1;
        n_vec++;
        if ({m1_rvalid, m0_rvalid, m0_rdata} !== {2'b01, 8'hA5}) begin
            n_err++; $display("FAIL read_return: got %h want %h", {m1_rvalid, m0_rvalid, m0_rdata}, {2'b01, 8'hA5});
        end
        next_cycle();
        n_vec++;
        if ({m0_rvalid, m0_rdata, rd_enb} !== 10'h0) begin
            n_err++; $display("FAIL read_done: got %h want 0", {m0_rvalid, m0_rdata, rd_enb});
        end
        clear_inputs();
    endtask

    task automatic test_alternate();
        do_reset();
        m0_req = 1; m1_req = 1; m0_addr = 8'h20; m1_addr = 8'h30;
        for (int i = 0; i < 6; i++) begin
            #1;
            n_vec++;
            if ({m1_gnt, m0_gnt, mem_addr} !== ((i % 2 == 0) ? {2'b01, 8'h20} : {2'b10, 8'h30})) begin
                n_err++; $display("FAIL alt_gnt[%0d]: got %h want %h", i, {m1_gnt, m0_gnt, mem_addr},
                                  ((i % 2 == 0) ? {2'b01, 8'h20} : {2'b10, 8'h30}));
            end
            if (i > 0) begin
                n_vec++;
                if ({m1_rvalid, m0_rvalid} !== ((i % 2 == 1) ? 2'b01 : 2'b10)) begin
                    n_err++; $display("FAIL alt_rvalid[%0d]: got %b want %b", i, {m1_rvalid, m0_rvalid},
                                      ((i % 2 == 1) ? 2'b01 : 2'b10));
                end
            end
            next_cycle();
        end
        clear_inputs();
    endtask

    task automatic test_back_to_back_writes();
        do_reset();
        m0_req = 1; m1_req = 1; m0_we = 1; m1_we = 1;
        m0_addr = 8'h01; m0_wdata = 8'h11; m1_addr = 8'h02; m1_wdata = 8'h22;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_vec++;
            if ({m1_gnt, m0_gnt, rd_enb, wr_enb, mem_wdata} !==
                ((i % 2 == 0) ? {4'b0101, 8'h11} : {4'b1001, 8'h22})) begin
                n_err++; $display("FAIL wr_issue[%0d]: got %h want %h", i, {m1_gnt, m0_gnt, rd_enb, wr_enb, mem_wdata},
                                  ((i % 2 == 0) ? {4'b0101, 8'h11} : {4'b1001, 8'h22}));
            end
            n_vec++;
            if ({m1_rvalid, m0_rvalid} !== 2'b00) begin
                n_err++; $display("FAIL wr_rvalid[%0d]: got %b want 00", i, {m1_rvalid, m0_rvalid});
            end
            next_cycle();
        end
        clear_inputs();
    endtask

    task automatic test_reset_inflight();
        do_reset();
        m0_req = 1; m0_we = 0; m0_addr = 8'h33;
        #1;
        n_vec++;
        if (m0_gnt !== 1'b1) begin
            n_err++; $display("FAIL inflight_gnt: got %b want 1", m0_gnt);
        end
        next_cycle();
        rst = 0; m1_req = 1; mem_rdata = 8'h5A;
        #1;
        n_vec++;
        if ({m0_rvalid, m0_rdata, m1_gnt, m0_gnt, rd_enb, wr_enb, mem_addr} !== 22'h0) begin
            n_err++; $display("FAIL inflight_kill: got %h want 0", {m0_rvalid, m0_rdata, m1_gnt, m0_gnt, rd_enb, wr_enb, mem_addr});
        end
        next_cycle();
        n_vec++;
        if ({m0_rvalid, m1_gnt, m0_gnt} !== 3'b000) begin
            n_err++; $display("FAIL inflight_hold: got %b want 000", {m0_rvalid, m1_gnt, m0_gnt});
        end
        rst = 1;
        next_cycle();
        n_vec++;
        if ({m1_gnt, m0_gnt} !== 2'b01) begin
            n_err++; $display("FAIL inflight_tie: got %b want 01", {m1_gnt, m0_gnt});
        end
        clear_inputs();
    endtask

`ifdef DMEM_ARB_LOCK_EN
    task automatic test_lock_forced();
        logic [1:0] exp_seq [6];
        exp_seq = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10};
        do_reset();
        m1_req = 1; m1_we = 1; m1_lock = 1; m1_wdata = 8'h77;
        for (int i = 0; i < 6; i++) begin
            #1;
            n_vec++;
            if ({m1_gnt, m0_gnt} !== exp_seq[i]) begin
                n_err++; $display("FAIL lock_forced[%0d]: got %b want %b", i, {m1_gnt, m0_gnt}, exp_seq[i]);
            end
            next_cycle();
            m0_req = 1;
        end
        clear_inputs();
    endtask

    task automatic test_lock_saturate();
        do_reset();
        m0_req = 1; m0_lock = 1; m0_we = 1;
        for (int i = 0; i < 8; i++) begin
            #1;
            n_vec++;
            if ({m1_gnt, m0_gnt} !== 2'b01) begin
                n_err++; $display("FAIL lock_sat[%0d]: got %b want 01", i, {m1_gnt, m0_gnt});
            end
            next_cycle();
        end
        // counter saturated at the limit: a newly arriving m1 wins at once
        m1_req = 1;
        #1;
        n_vec++;
        if ({m1_gnt, m0_gnt} !== 2'b10) begin
            n_err++; $display("FAIL lock_sat_release: got %b want 10", {m1_gnt, m0_gnt});
        end
        clear_inputs();
    endtask
`else
    task automatic test_lock_ignored();
        do_reset();
        m0_req = 1; m1_req = 1; m0_lock = 1; m1_lock = 1;
        for (int i = 0; i < 6; i++) begin
            #1;
            n_vec++;
            if ({m1_gnt, m0_gnt} !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
                n_err++; $display("FAIL lock_ignored[%0d]: got %b want %b", i, {m1_gnt, m0_gnt},
                                  ((i % 2 == 0) ? 2'b01 : 2'b10));
            end
            next_cycle();
        end
        clear_inputs();
    endtask
`endif

    initial begin
        clear_inputs();
        rst = 0;
        test_reset();
        test_read();
        test_alternate();
        test_back_to_back_writes();
        test_reset_inflight();
`ifdef DMEM_ARB_LOCK_EN
        test_lock_forced();
        test_lock_saturate();
`else
        test_lock_ignored();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 8: data memory address width.
REQ-002 SHALL have parameter DW, default 8: data memory data width.
REQ-003 SHALL have parameter LOCK_MAX, default 4: maximum consecutive locked grants to one requester (range 1..15).
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port mN_req  input  1  requester N (N=0 processor, N=1 debug/DMA) access request, held until granted.
REQ-007 SHALL have port mN_we  input  1  1 = write, 0 = read.
REQ-008 SHALL have port mN_lock  input  1  request to keep ownership on the next cycle.
REQ-009 SHALL have port mN_addr  input  AW  access address.
REQ-010 SHALL have port mN_wdata  input  DW  write data.
REQ-011 SHALL have port mN_gnt  output  1  access issued to memory this cycle.
REQ-012 SHALL have port mN_rvalid  output  1  read data valid, one cycle after a granted read.
REQ-013 SHALL have port mN_rdata  output  DW  read data, qualified by mN_rvalid.
REQ-014 SHALL have port data_mem_rd_enb_o  output  1  memory read strobe.
REQ-015 SHALL have port data_mem_wr_enb_o  output  1  memory write strobe.
REQ-016 SHALL have port data_mem_addr_o  output  AW  memory address.
REQ-017 SHALL have port data_mem_wr_data_o  output  DW  memory write data.
REQ-018 SHALL have port data_mem_rd_data_i  input  DW  memory read data, valid one cycle after data_mem_rd_enb_o.

Function
REQ-019 SHALL grant at most one requester per cycle; mN_gnt is combinational from current state and requests.
REQ-020 SHALL drive memory outputs from the granted requester in the grant cycle: rd_enb = ~we, wr_enb = we; with no grant, enables are 0 and addr/wr_data are 0.
REQ-021 SHALL be an FSM with states IDLE, LOCK0, LOCK1.
REQ-022 In IDLE, single requester SHALL be granted; with both requesting, SHALL grant the requester other than last_gnt (round-robin), then update last_gnt.
REQ-023 A grant with mN_lock=1 SHALL move to LOCKN and increment lock_cnt; LOCKN grants requester N exclusively whenever mN_req=1.
REQ-024 LOCKN SHALL return to IDLE when mN_lock=0 on a granted cycle, when mN_req=0, or when lock_cnt reaches LOCK_MAX while the other requester is requesting; lock_cnt clears on entering IDLE.
REQ-025 When lock_cnt reaches LOCK_MAX with the other requester idle, SHALL stay in LOCKN with lock_cnt saturated.
REQ-026 After a forced release, the other requester SHALL be granted in the next cycle (last_gnt forces it).
REQ-027 Read latency SHALL be exactly one cycle: mN_rvalid registered from (mN_gnt & ~mN_we); mN_rdata = data_mem_rd_data_i when valid, else 0.
REQ-028 Writes SHALL produce no rvalid; back-to-back grants SHALL be sustained every cycle (full throughput).
REQ-029 A requester that drops mN_req before grant SHALL be treated as never having requested.

Reset
REQ-030 rst=0 SHALL asynchronously force IDLE, lock_cnt=0, last_gnt=1 (m0 wins the first tie), all outputs 0, in-flight rvalid discarded.
REQ-031 First grant after rst deassertion SHALL occur no earlier than the first rising clk edge with rst=1.

Configuration
REQ-032 Macro DMEM_ARB_LOCK_EN defined: lock behaviour per REQ-023..026.
REQ-033 DMEM_ARB_LOCK_EN undefined: mN_lock ignored, LOCK0/LOCK1 and lock_cnt absent, pure per-cycle round-robin.

Structure
REQ-034 Package dmem_arb_pkg SHALL hold the FSM state enum, the requester index type, and default AW/DW constants.
REQ-035 One sub-module dmem_arb_rr SHALL implement the two-way round-robin pick (inputs: reqs, last_gnt; output: one-hot grant).

Verification
REQ-036 m0 read addr 0x10 alone, memory returns 0xA5 -> m0_gnt cycle 0, rd_enb=1 addr=0x10, m0_rvalid=1 rdata=0xA5 cycle 1.
REQ-037 Both request continuously, no lock, after reset -> grants m0,m1,m0,m1..., one per cycle.
REQ-038 LOCK_MAX=4, m1 locked writes while m0 requests -> 4 m1 grants, then m0 grant, then m1.
REQ-039 m0 locked, m1 idle, 8 cycles -> 8 consecutive m0 grants, lock_cnt holds 4.
REQ-040 rst low the cycle after a granted read -> m0_rvalid stays 0, all outputs 0, next tie goes to m0.
REQ-041 Build without DMEM_ARB_LOCK_EN, m1_lock=1, both requesting -> strict alternation as REQ-037.
